// File: rtl/hdc1080_axil_regbank_pkg.sv
`default_nettype none
// ============================================================================
// hdc1080_axil_pkg : register map, STATUS bits, AXI response/FSM types
// Revision 1.0
// ============================================================================
package hdc1080_axil_pkg;

   localparam int IDX_CTRL     = 0;
   localparam int IDX_CONFIG   = 1;
   localparam int IDX_STATUS   = 2;
   localparam int IDX_TEMP     = 3;
   localparam int IDX_HUM      = 4;
   localparam int IDX_SCRATCH0 = 5;

   localparam int ST_DONE = 0;
   localparam int ST_OVR  = 1;
   localparam int ST_BUSY = 2;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

   typedef enum logic [0:0] {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } wfsm_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rfsm_t;

   // Worked at the widest supported bus; callers cast to DATA_W.
   function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  wstrb);
      logic [63:0] res;
      res = old_v;
      for (int b = 0; b < 8; b++) begin
         if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hdc1080_axil_regbank_if.sv
`default_nettype none
// ============================================================================
// hdc1080_axil_regbank_if : AXI4-Lite bundle with master/slave modports
// Revision 1.0
// ============================================================================
interface hdc1080_axil_regbank_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface
`default_nettype wire

// File: rtl/hdc1080_axil_regbank.sv
`default_nettype none
// ============================================================================
// hdc1080_axil_regbank : AXI4-Lite register bank for the HDC1080 sensor core
// Revision 1.0
// ============================================================================
module hdc1080_axil_regbank
   import hdc1080_axil_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                NUM_SCRATCH = 4,
   parameter int                SAMPLE_W    = 16,
   parameter logic [DATA_W-1:0] CFG_RESET   = '0
)(
   input  wire logic                ACLK,
   input  wire logic                ARESET,
   hdc1080_axil_regbank_if.slave    s_axi,
   output logic                     meas_start,
   output logic [DATA_W-1:0]        cfg_out,
   input  wire logic                busy_in,
   input  wire logic                meas_done,
   input  wire logic [SAMPLE_W-1:0] temp_in,
   input  wire logic [SAMPLE_W-1:0] hum_in
);
   localparam int NREGS  = 5 + NUM_SCRATCH;
   localparam int IDX_W  = $clog2(NREGS);
   localparam int LSB_W  = $clog2(DATA_W / 8);
   localparam int ADDR_W = IDX_W + LSB_W;
   localparam int SCR_N  = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

   wfsm_t               wstate;
   rfsm_t               rstate;
   logic                done;
   logic                ovr;
   logic [SAMPLE_W-1:0] temp;
   logic [SAMPLE_W-1:0] hum;
   logic [DATA_W-1:0]   scratch [SCR_N];

   logic [IDX_W-1:0]    widx;
   logic [IDX_W-1:0]    ridx;
   logic                wr_acc;
   logic                wr_err;
   logic                start_req;
   logic                clr_done;
   logic                clr_ovr;
   logic [DATA_W-1:0]   rd_data;
   logic                rd_err;
   logic                unused_bits;

   assign widx = s_axi.awaddr[ADDR_W-1:LSB_W];
   assign ridx = s_axi.araddr[ADDR_W-1:LSB_W];

   // Ready is raised one cycle after both valids are seen; the handshake edge is the update edge.
   assign wr_acc    = (wstate == W_IDLE) && s_axi.awready && s_axi.awvalid && s_axi.wvalid;
   assign wr_err    = (int'(widx) >= NREGS) || (int'(widx) == IDX_TEMP) || (int'(widx) == IDX_HUM);
   assign start_req = wr_acc && (int'(widx) == IDX_CTRL) && s_axi.wstrb[0] && s_axi.wdata[0];
   assign clr_done  = wr_acc && (int'(widx) == IDX_STATUS) && s_axi.wstrb[0] && s_axi.wdata[ST_DONE];
   assign clr_ovr   = wr_acc && (int'(widx) == IDX_STATUS) && s_axi.wstrb[0] && s_axi.wdata[ST_OVR];

   assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                          s_axi.awaddr[LSB_W-1:0], s_axi.araddr[LSB_W-1:0]};

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wstate        <= W_IDLE;
         s_axi.awready <= 1'b0;
         s_axi.wready  <= 1'b0;
         s_axi.bvalid  <= 1'b0;
         s_axi.bresp   <= RESP_OKAY;
         meas_start    <= 1'b0;
         cfg_out       <= CFG_RESET;
         done          <= 1'b0;
         ovr           <= 1'b0;
         temp          <= '0;
         hum           <= '0;
         for (int i = 0; i < SCR_N; i++) scratch[i] <= '0;
      end else begin
         meas_start <= start_req && !busy_in;

         case (wstate)
            W_IDLE: begin
               if (s_axi.awready) begin
                  s_axi.awready <= 1'b0;
                  s_axi.wready  <= 1'b0;
                  s_axi.bvalid  <= 1'b1;
                  s_axi.bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
                  wstate        <= W_RESP;
               end else if (s_axi.awvalid && s_axi.wvalid) begin
                  s_axi.awready <= 1'b1;
                  s_axi.wready  <= 1'b1;
               end
            end
            W_RESP: begin
               if (s_axi.bready) begin
                  s_axi.bvalid <= 1'b0;
                  wstate       <= W_IDLE;
               end
            end
            default: wstate <= W_IDLE;
         endcase

         if (wr_acc && (int'(widx) == IDX_CONFIG))
            cfg_out <= DATA_W'(strb_merge(64'(cfg_out), 64'(s_axi.wdata), 8'(s_axi.wstrb)));
         for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (wr_acc && (int'(widx) == IDX_SCRATCH0 + i))
               scratch[i] <= DATA_W'(strb_merge(64'(scratch[i]), 64'(s_axi.wdata), 8'(s_axi.wstrb)));
         end

         if (meas_done) begin
            temp <= temp_in;
            hum  <= hum_in;
         end
         // Set sources take priority over a same-cycle W1C.
         done <= meas_done | (done & ~clr_done);
         ovr  <= (start_req & busy_in) | (ovr & ~clr_ovr);
      end
   end

   always_comb begin
      rd_data = '0;
      rd_err  = 1'b0;
      case (int'(ridx))
         IDX_CTRL:   rd_data = '0;
         IDX_CONFIG: rd_data = cfg_out;
         IDX_STATUS: begin
            rd_data[ST_DONE] = done;
            rd_data[ST_OVR]  = ovr;
            rd_data[ST_BUSY] = busy_in;
         end
         IDX_TEMP:   rd_data = DATA_W'(temp);
         IDX_HUM:    rd_data = DATA_W'(hum);
         default: begin
            rd_err = 1'b1;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
               if (int'(ridx) == IDX_SCRATCH0 + i) begin
                  rd_data = scratch[i];
                  rd_err  = 1'b0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rstate        <= R_IDLE;
         s_axi.arready <= 1'b0;
         s_axi.rvalid  <= 1'b0;
         s_axi.rdata   <= '0;
         s_axi.rresp   <= RESP_OKAY;
      end else begin
         case (rstate)
            R_IDLE: begin
               s_axi.arready <= 1'b1;
               if (s_axi.arready && s_axi.arvalid) begin
                  s_axi.arready <= 1'b0;
                  s_axi.rvalid  <= 1'b1;
                  s_axi.rdata   <= rd_data;
                  s_axi.rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
                  rstate        <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_axi.rready) begin
                  s_axi.rvalid  <= 1'b0;
                  s_axi.arready <= 1'b1;
                  rstate        <= R_IDLE;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hdc1080_axil_regbank.sv
`default_nettype none
// ============================================================================
// tb_hdc1080_axil_regbank : directed self-checking bench for the register bank
// Revision 1.0
// ============================================================================
module tb_hdc1080_axil_regbank;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 6;

   logic        clk;
   logic        rst;
   logic        meas_start;
   logic [31:0] cfg_out;
   logic        busy_in;
   logic        meas_done;
   logic [15:0] temp_in;
   logic [15:0] hum_in;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;

   hdc1080_axil_regbank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_axi ();

   hdc1080_axil_regbank #(
      .DATA_W(DATA_W), .NUM_SCRATCH(4), .SAMPLE_W(16), .CFG_RESET(32'h0)
   ) dut (
      .ACLK(clk), .ARESET(rst), .s_axi(s_axi),
      .meas_start(meas_start), .cfg_out(cfg_out), .busy_in(busy_in),
      .meas_done(meas_done), .temp_in(temp_in), .hum_in(hum_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (meas_start === 1'b1) pulses++;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic md, output logic [1:0] resp, output logic ms);
      s_axi.awaddr = a; s_axi.wdata = d; s_axi.wstrb = s;
      s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.bready = 1'b1;
      for (int i = 0; i < 20 && s_axi.awready !== 1'b1; i++) begin @(posedge clk); #1; end
      check("wr_awready", s_axi.awready, 1);
      meas_done = md;
      @(posedge clk); #1;
      s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; meas_done = 1'b0;
      check("wr_bvalid_next", s_axi.bvalid, 1);
      resp = s_axi.bresp;
      ms   = meas_start;
      @(posedge clk); #1;
      s_axi.bready = 1'b0;
   endtask

   task automatic axi_read(input logic [5:0] a, input logic md,
                           output logic [31:0] d, output logic [1:0] resp);
      s_axi.araddr = a; s_axi.arvalid = 1'b1; s_axi.rready = 1'b1;
      for (int i = 0; i < 20 && s_axi.arready !== 1'b1; i++) begin @(posedge clk); #1; end
      check("rd_arready", s_axi.arready, 1);
      meas_done = md;
      @(posedge clk); #1;
      s_axi.arvalid = 1'b0; meas_done = 1'b0;
      check("rd_rvalid", s_axi.rvalid, 1);
      d    = s_axi.rdata;
      resp = s_axi.rresp;
      @(posedge clk); #1;
      s_axi.rready = 1'b0;
   endtask

   initial begin
      logic [1:0]  resp;
      logic [31:0] rd;
      logic        ms;
      int          p0;
      int          bad;

      rst = 1'b1; busy_in = 1'b0; meas_done = 1'b0; temp_in = '0; hum_in = '0;
      s_axi.awaddr = '0; s_axi.awprot = '0; s_axi.awvalid = 1'b0;
      s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
      s_axi.araddr = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_awready", s_axi.awready, 0);
      check("rst_wready",  s_axi.wready, 0);
      check("rst_bvalid",  s_axi.bvalid, 0);
      check("rst_arready", s_axi.arready, 0);
      check("rst_rvalid",  s_axi.rvalid, 0);
      check("rst_rdata",   s_axi.rdata, 0);
      check("rst_resp",    {s_axi.bresp, s_axi.rresp}, 0);
      check("rst_cfg",     cfg_out, 0);
      check("rst_start",   meas_start, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Scratch registers 5..8 at byte addresses 0x14..0x20
      for (int k = 0; k < 4; k++) begin
         axi_write(6'(8'h14 + 4*k), 32'hA5A5_0001 + k, 4'hF, 1'b0, resp, ms);
         check("scr_bresp", resp, 2'b00);
      end
      for (int k = 0; k < 4; k++) begin
         axi_read(6'(8'h14 + 4*k), 1'b0, rd, resp);
         check("scr_rdata", rd, 32'hA5A5_0001 + k);
         check("scr_rresp", resp, 2'b00);
      end

      axi_write(6'h04, 32'hFFFF_FFFF, 4'b0010, 1'b0, resp, ms);
      check("cfg_bresp", resp, 2'b00);
      check("cfg_out", cfg_out, 32'h0000_FF00);
      axi_read(6'h04, 1'b0, rd, resp);
      check("cfg_rdata", rd, 32'h0000_FF00);

      // START while idle
      p0 = pulses;
      axi_write(6'h00, 32'h1, 4'h1, 1'b0, resp, ms);
      check("start_pulse_now", ms, 1);
      repeat (3) @(posedge clk);
      #1;
      check("start_pulse_count", pulses - p0, 1);
      axi_read(6'h00, 1'b0, rd, resp);
      check("ctrl_reads_zero", rd, 0);

      temp_in = 16'h6400; hum_in = 16'h8000; meas_done = 1'b1;
      @(posedge clk); #1;
      meas_done = 1'b0;
      axi_read(6'h0C, 1'b0, rd, resp);
      check("temp_rdata", rd, 32'h0000_6400);
      axi_read(6'h10, 1'b0, rd, resp);
      check("hum_rdata", rd, 32'h0000_8000);
      axi_read(6'h08, 1'b0, rd, resp);
      check("status_done", rd, 32'h1);
      axi_write(6'h08, 32'h1, 4'h1, 1'b0, resp, ms);
      axi_read(6'h08, 1'b0, rd, resp);
      check("status_w1c", rd, 32'h0);

      // START while busy -> overrun
      busy_in = 1'b1;
      p0 = pulses;
      axi_write(6'h00, 32'h1, 4'h1, 1'b0, resp, ms);
      check("busy_bresp", resp, 2'b00);
      repeat (3) @(posedge clk);
      #1;
      check("busy_no_pulse", pulses - p0, 0);
      axi_read(6'h08, 1'b0, rd, resp);
      check("status_ovr_busy", rd, 32'h6);

      temp_in = 16'h1234; hum_in = 16'h5678;
      axi_write(6'h08, 32'h1, 4'h1, 1'b1, resp, ms);
      axi_read(6'h08, 1'b0, rd, resp);
      check("done_set_wins", rd, 32'h7);
      busy_in = 1'b0;
      axi_write(6'h08, 32'h3, 4'h1, 1'b0, resp, ms);
      axi_read(6'h08, 1'b0, rd, resp);
      check("status_clear_all", rd, 32'h0);

      temp_in = 16'hBEEF;
      axi_read(6'h0C, 1'b1, rd, resp);
      check("temp_old_on_capture", rd, 32'h0000_1234);
      axi_read(6'h0C, 1'b0, rd, resp);
      check("temp_new", rd, 32'h0000_BEEF);

      // Decode errors
      axi_read(6'h24, 1'b0, rd, resp);
      check("oor_rresp", resp, 2'b10);
      check("oor_rdata", rd, 0);
      axi_write(6'h0C, 32'hFFFF_FFFF, 4'hF, 1'b0, resp, ms);
      check("temp_wr_bresp", resp, 2'b10);
      axi_read(6'h0C, 1'b0, rd, resp);
      check("temp_unchanged", rd, 32'h0000_BEEF);
      axi_write(6'h24, 32'hFFFF_FFFF, 4'hF, 1'b0, resp, ms);
      check("oor_bresp", resp, 2'b10);

      // AW ahead of W, then slow B acceptance
      bad = 0;
      s_axi.awaddr = 6'h14; s_axi.wdata = 32'hCAFE_0005; s_axi.wstrb = 4'hF;
      s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (s_axi.awready !== 1'b0 || s_axi.wready !== 1'b0 || s_axi.bvalid !== 1'b0) bad++;
      end
      check("aw_no_early_accept", bad, 0);
      s_axi.wvalid = 1'b1;
      for (int i = 0; i < 20 && s_axi.awready !== 1'b1; i++) begin @(posedge clk); #1; end
      check("aw_late_ready", s_axi.awready, 1);
      @(posedge clk); #1;
      s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
      bad = 0;
      repeat (5) begin
         if (s_axi.bvalid !== 1'b1 || s_axi.bresp !== 2'b00) bad++;
         @(posedge clk); #1;
      end
      check("bvalid_held", bad, 0);
      s_axi.bready = 1'b1;
      @(posedge clk); #1;
      check("bvalid_drop", s_axi.bvalid, 0);
      s_axi.bready = 1'b0;
      axi_read(6'h14, 1'b0, rd, resp);
      check("late_w_data", rd, 32'hCAFE_0005);

      // Reset while read data is pending
      s_axi.araddr = 6'h04; s_axi.arvalid = 1'b1; s_axi.rready = 1'b0;
      for (int i = 0; i < 20 && s_axi.arready !== 1'b1; i++) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      s_axi.arvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rdata_held", {s_axi.rvalid, s_axi.rdata}, {1'b1, 32'h0000_FF00});
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_rvalid", s_axi.rvalid, 0);
      check("rst_mid_cfg", cfg_out, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mid_no_r", s_axi.rvalid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
